axi4lite_slave_memory: RTL and testbench

AXI4-Lite slave backed by a 256 × 32-bit word memory. It is the bus-side target for the PicoRV32 AXI adapter in the adapter verification environment. It accepts single-beat reads and byte-strobed writes. It also exposes the full memory array as an output, so checkers can compare against a reference model. It has no `awprot`/`arprot` inputs; protection is ignored.

---
 rtl/axi4lite_slave_memory_if.sv | 35 +++
 rtl/axi4lite_slave_memory.sv | 122 ++++++++++++
 tb/tb_axi4lite_slave_memory.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4lite_slave_memory_if.sv
// AXI4-Lite bus bundle for axi4lite_slave_memory (no prot, no resp signals).
// Groups:
//   AW: awvalid, awready, awaddr[31:0]
//   W : wvalid, wready, wdata[31:0], wstrb[3:0]
//   B : bvalid, bready
//   AR: arvalid, arready, araddr[31:0]
//   R : rvalid, rready, rdata[31:0]
// The slave modport is used by the memory. The master modport is used by whatever drives it.
interface axi4lite_slave_memory_if;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid;
    logic        bready;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, arready, rvalid, rdata
    );

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, arready, rvalid, rdata
    );
endinterface

// File: rtl/axi4lite_slave_memory.sv
// AXI4-Lite slave backed by a 256 x 32-bit memory.
// Ports:
//   clk    - rising-edge clock
//   resetn - synchronous active-low reset; clears the bus state and every memory word
//   bus    - AXI4-Lite slave channels (AW, W, B, AR, R)
//   memory - live view of the storage array
// The word index is addr[9:2], so addresses alias modulo 1 KiB.
// Every ready is a registered one-cycle pulse.
// Only one read and one write are in flight at a time.
module axi4lite_slave_memory (
    input  logic                          clk,
    input  logic                          resetn,
    axi4lite_slave_memory_if.slave        bus,
    output logic [31:0]                   memory [0:255]
);
    localparam int unsigned DEPTH  = 256;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned IDX_W  = 8;
    localparam int unsigned STRB_W = DATA_W / 8;

    logic              aw_held;
    logic              w_held;
    logic [IDX_W-1:0]  aw_idx;
    logic [DATA_W-1:0] w_data;
    logic [STRB_W-1:0] w_strb;
    logic [DATA_W-1:0] w_mask_c;
    logic [IDX_W-1:0]  ar_idx_c;
    logic [IDX_W-1:0]  awaddr_idx_c;
    logic              commit_c;
    logic              aw_hs_c;
    logic              w_hs_c;
    logic              ar_hs_c;
    logic              unused_addr_bits;

    assign ar_idx_c     = bus.araddr[9:2];
    assign awaddr_idx_c = bus.awaddr[9:2];
    assign aw_hs_c      = bus.awvalid && bus.awready;
    assign w_hs_c       = bus.wvalid && bus.wready;
    assign ar_hs_c      = bus.arvalid && bus.arready;
    assign commit_c     = aw_held && w_held && !bus.bvalid;

    // Address bits outside the word index are intentionally ignored.
    assign unused_addr_bits = ^{bus.awaddr[31:10], bus.awaddr[1:0],
                                bus.araddr[31:10], bus.araddr[1:0]};

    // Expand the byte strobes into a bit mask.
    always_comb begin
        w_mask_c = '0;
        for (int unsigned b = 0; b < STRB_W; b++) begin
            w_mask_c[b*8 +: 8] = {8{w_strb[b]}};
        end
    end

    // Read channel: one-cycle arready pulse, then rvalid/rdata held until rready.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            bus.arready <= 1'b0;
            bus.rvalid  <= 1'b0;
            bus.rdata   <= '0;
        end else begin
            bus.arready <= bus.arvalid && !bus.arready && !bus.rvalid;
            if (ar_hs_c) begin
                // Nonblocking update, so a write committing on this edge is not yet visible.
                bus.rdata  <= memory[ar_idx_c];
                bus.rvalid <= 1'b1;
            end else if (bus.rready) begin
                bus.rvalid <= 1'b0;
            end
        end
    end

    // Write channels: AW and W latch independently, then commit together.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            bus.awready <= 1'b0;
            bus.wready  <= 1'b0;
            bus.bvalid  <= 1'b0;
            aw_held     <= 1'b0;
            w_held      <= 1'b0;
            aw_idx      <= '0;
            w_data      <= '0;
            w_strb      <= '0;
        end else begin
            bus.awready <= bus.awvalid && !bus.awready && !aw_held && !bus.bvalid;
            bus.wready  <= bus.wvalid && !bus.wready && !w_held && !bus.bvalid;

            // A handshake needs !held at the previous edge, and a commit needs held now,
            // so a handshake and a commit never fall on the same edge.
            if (aw_hs_c) begin
                aw_idx  <= awaddr_idx_c;
                aw_held <= 1'b1;
            end else if (commit_c) begin
                aw_held <= 1'b0;
            end

            if (w_hs_c) begin
                w_data <= bus.wdata;
                w_strb <= bus.wstrb;
                w_held <= 1'b1;
            end else if (commit_c) begin
                w_held <= 1'b0;
            end

            if (commit_c) begin
                bus.bvalid <= 1'b1;
            end else if (bus.bready) begin
                bus.bvalid <= 1'b0;
            end
        end
    end

    // Storage: cleared on reset; strobed bytes merged in on commit.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                memory[IDX_W'(i)] <= '0;
            end
        end else if (commit_c) begin
            memory[aw_idx] <= (memory[aw_idx] & ~w_mask_c) | (w_data & w_mask_c);
        end
    end
endmodule

// File: tb/tb_axi4lite_slave_memory.sv
// Self-checking bench for axi4lite_slave_memory.
// A vector table drives the main reads and writes. Hand-written sequences cover the multi-cycle corners.
// Expected read data goes into a scoreboard queue when AR is driven and is checked when rvalid appears.
module tb_axi4lite_slave_memory;
    logic clk = 1'b0;
    logic resetn;
    logic [31:0] memory [0:255];

    always #5 clk = ~clk;

    axi4lite_slave_memory_if bus ();

    axi4lite_slave_memory dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus),
        .memory (memory)
    );

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;

    localparam int NVEC = 13;
    vec_t        vecs [NVEC];
    logic [31:0] sb_q [$];
    logic [31:0] ref_mem [256];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic apply_ref(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) ref_mem[addr[9:2]][b*8 +: 8] = data[b*8 +: 8];
        end
    endtask

    // Ready-pulse rule: no ready may be high on two consecutive samples.
    logic prev_ar = 1'b0, prev_aw = 1'b0, prev_w = 1'b0;
    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            checks++;
            if ((prev_ar && bus.arready) || (prev_aw && bus.awready) || (prev_w && bus.wready)) begin
                errors++;
                $display("FAIL ready_pulse: ar=%0b aw=%0b w=%0b held for two cycles, required single pulse",
                         bus.arready, bus.awready, bus.wready);
            end
        end
        prev_ar = bus.arready;
        prev_aw = bus.awready;
        prev_w  = bus.wready;
    end

    // Wait for the AW and/or W handshakes on the valids already driven. Each valid drops right after its handshake.
    task automatic wait_write_hs(input bit need_aw, input bit need_w, output bit ok);
        bit aw_done, w_done, aw_hs, w_hs;
        aw_done = !need_aw;
        w_done  = !need_w;
        ok      = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            aw_hs = bus.awvalid && bus.awready;
            w_hs  = bus.wvalid && bus.wready;
            @(posedge clk);
            #1;
            if (aw_hs) begin bus.awvalid = 1'b0; aw_done = 1'b1; end
            if (w_hs)  begin bus.wvalid  = 1'b0; w_done  = 1'b1; end
            if (aw_done && w_done) begin ok = 1'b1; break; end
        end
    endtask

    // Count the negedges until bvalid is seen; -1 means the bound ran out.
    task automatic wait_bvalid(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.bvalid) begin cyc = i; break; end
        end
    endtask

    // Drive AW and W together and run to bvalid. If bready is high, also wait for the response to be taken.
    task automatic axi_write(input vec_t v, output int bcyc);
        bit ok;
        @(negedge clk);
        bus.awaddr  = v.addr;
        bus.wdata   = v.data;
        bus.wstrb   = v.strb;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        wait_write_hs(1'b1, 1'b1, ok);
        chk("write_handshake_timeout", 32'(ok), 32'd1);
        wait_bvalid(bcyc);
        chk("bvalid_timeout", 32'(bcyc > 0), 32'd1);
        apply_ref(v.addr, v.data, v.strb);
        chk("write_memory_word", memory[v.addr[9:2]], v.exp);
        if (bus.bready) begin
            @(posedge clk);
            #1;
            chk("bvalid_clears", 32'(bus.bvalid), 32'd0);
        end
    endtask

    // Drive AR, queue the expected data, and compare it when rvalid shows up.
    task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp, output int lat);
        bit seen;
        logic [31:0] want;
        @(negedge clk);
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        sb_q.push_back(exp);
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge clk);
            lat++;
            if (i == 0) continue;
            if (bus.arready) begin seen = 1'b1; break; end
        end
        chk("arready_timeout", 32'(seen), 32'd1);
        @(posedge clk);
        #1;
        bus.arvalid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (bus.rvalid) begin seen = 1'b1; break; end
        end
        chk("rvalid_timeout", 32'(seen), 32'd1);
        if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            want = sb_q.pop_front();
            chk("read_data", bus.rdata, want);
        end
        lat = lat - 1;
        if (bus.rready) begin
            @(posedge clk);
            #1;
            chk("rvalid_clears", 32'(bus.rvalid), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   bcyc, lat, nmis;
        bit   ok;
        vec_t v;

        vecs[0]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'h0000_0000};
        vecs[1]  = '{1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b0, 32'h0000_0004, 32'h0,         4'h0, 32'hDEAD_BEEF};
        vecs[3]  = '{1'b1, 32'h0000_0004, 32'h1122_3344, 4'h6, 32'hDE22_33EF};
        vecs[4]  = '{1'b0, 32'h0000_0004, 32'h0,         4'h0, 32'hDE22_33EF};
        vecs[5]  = '{1'b1, 32'h0000_03FC, 32'h1234_5678, 4'hF, 32'h1234_5678};
        vecs[6]  = '{1'b0, 32'hFFFF_FFFF, 32'h0,         4'h0, 32'h1234_5678};
        vecs[7]  = '{1'b1, 32'h0000_0008, 32'hCAFE_F00D, 4'h0, 32'h0000_0000};
        vecs[8]  = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, 32'h0000_0000};
        vecs[9]  = '{1'b1, 32'h0000_0008, 32'h0000_00AB, 4'h1, 32'h0000_00AB};
        vecs[10] = '{1'b0, 32'h0000_000A, 32'h0,         4'h0, 32'h0000_00AB};
        vecs[11] = '{1'b1, 32'h0000_0400, 32'hA5A5_A5A5, 4'hF, 32'hA5A5_A5A5};
        vecs[12] = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'hA5A5_A5A5};

        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
        bus.awvalid = 1'b0; bus.awaddr = '0;
        bus.wvalid  = 1'b0; bus.wdata  = '0; bus.wstrb = '0;
        bus.arvalid = 1'b0; bus.araddr = '0;
        bus.bready  = 1'b1; bus.rready = 1'b1;

        // Reset state.
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_arready", 32'(bus.arready), 32'd0);
        chk("rst_awready", 32'(bus.awready), 32'd0);
        chk("rst_wready",  32'(bus.wready),  32'd0);
        chk("rst_bvalid",  32'(bus.bvalid),  32'd0);
        chk("rst_rvalid",  32'(bus.rvalid),  32'd0);
        chk("rst_rdata",   bus.rdata,        32'd0);
        chk("rst_mem0",    memory[0],        32'd0);
        chk("rst_mem255",  memory[255],      32'd0);
        resetn = 1'b1;

        // Table-driven reads and writes.
        for (int i = 0; i < NVEC; i++) begin
            if (vecs[i].is_wr) begin
                axi_write(vecs[i], bcyc);
                if (i == 1) chk("write_latency", 32'(bcyc), 32'd2);
            end else begin
                axi_read(vecs[i].addr, vecs[i].exp, lat);
                if (i == 0) chk("read_latency", 32'(lat), 32'd2);
            end
        end

        // W is issued three cycles ahead of AW; nothing commits until AW arrives.
        @(negedge clk);
        bus.wdata  = 32'h0BAD_F00D;
        bus.wstrb  = 4'hF;
        bus.wvalid = 1'b1;
        wait_write_hs(1'b0, 1'b1, ok);
        chk("w_only_handshake", 32'(ok), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("w_early_no_bvalid", 32'(bus.bvalid), 32'd0);
            chk("w_early_no_wready", 32'(bus.wready), 32'd0);
            chk("w_early_mem",       memory[3],       32'd0);
        end
        bus.awaddr  = 32'h0000_000C;
        bus.awvalid = 1'b1;
        wait_write_hs(1'b1, 1'b0, ok);
        chk("aw_late_handshake", 32'(ok), 32'd1);
        wait_bvalid(bcyc);
        chk("w_early_bvalid", 32'(bcyc > 0), 32'd1);
        apply_ref(32'h0000_000C, 32'h0BAD_F00D, 4'hF);
        chk("w_early_mem_after", memory[3], 32'h0BAD_F00D);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("w_early_single_bvalid", 32'(bus.bvalid), 32'd0);
        end

        // bready held low: the response stays up and a second write is blocked.
        bus.bready = 1'b0;
        v = '{1'b1, 32'h0000_0014, 32'h1111_1111, 4'hF, 32'h1111_1111};
        axi_write(v, bcyc);
        @(negedge clk);
        bus.awaddr  = 32'h0000_0014;
        bus.wdata   = 32'h2222_2222;
        bus.wstrb   = 4'hF;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bstall_bvalid",  32'(bus.bvalid),  32'd1);
            chk("bstall_awready", 32'(bus.awready), 32'd0);
            chk("bstall_wready",  32'(bus.wready),  32'd0);
            chk("bstall_mem",     memory[5],        32'h1111_1111);
        end
        bus.bready = 1'b1;
        wait_write_hs(1'b1, 1'b1, ok);
        chk("bstall_second_hs", 32'(ok), 32'd1);
        wait_bvalid(bcyc);
        chk("bstall_second_bvalid", 32'(bcyc > 0), 32'd1);
        apply_ref(32'h0000_0014, 32'h2222_2222, 4'hF);
        chk("bstall_mem_after", memory[5], 32'h2222_2222);
        @(posedge clk);
        #1;

        // Full memory against the reference model.
        nmis = 0;
        for (int i = 0; i < 256; i++) if (memory[i] !== ref_mem[i]) nmis++;
        chk("memory_mismatch_words", 32'(nmis), 32'd0);

        // Reset during a pending read response.
        bus.rready = 1'b0;
        @(negedge clk);
        bus.araddr  = 32'h0;
        bus.arvalid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.arready) begin ok = 1'b1; break; end
        end
        chk("rstread_arready", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        bus.arvalid = 1'b0;
        @(negedge clk);
        chk("rstread_rvalid_pending", 32'(bus.rvalid), 32'd1);
        chk("rstread_rdata_pending",  bus.rdata,       32'hA5A5_A5A5);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        chk("rstread_rvalid", 32'(bus.rvalid), 32'd0);
        chk("rstread_rdata",  bus.rdata,       32'd0);
        chk("rstread_mem0",   memory[0],       32'd0);
        chk("rstread_mem1",   memory[1],       32'd0);
        @(negedge clk);
        resetn     = 1'b1;
        bus.rready = 1'b1;
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;

        axi_read(32'h0000_0004, 32'h0, lat);
        chk("post_reset_read_latency", 32'(lat), 32'd2);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
